logic_function_bist: RTL

- On-board built-in self test for the 3-input/2-output logic_functions block.
- Sequencer side of the vector exchange: drives every input combination into the DUT, waits a settle window, samples O1/O2 and compares them with a golden truth table held in parameters.
- Counts mismatches, captures the first failing vector, and reports pass/fail to board LEDs or the top level.
- Sits beside logic_functions in the lab top level. A start button pulse launches a sweep.

---
 rtl/lf_bist_pkg.sv | 9 +
 rtl/lf_expect_lut.sv | 11 +
 rtl/logic_function_bist.sv | 88 ++++++++
 3 files changed

// File: rtl/lf_bist_pkg.sv
// lf_bist_pkg: shared state encoding, golden tables and mismatch counter for the logic_functions BIST
package lf_bist_pkg;
  typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_e;
  localparam logic [7:0] LF_EXP_O1 = 8'hAC;
  localparam logic [7:0] LF_EXP_O2 = 8'h80;
  function automatic logic [1:0] popcount2(input logic [1:0] x);
    return {x[1] & x[0], x[1] ^ x[0]};
  endfunction
endpackage

// File: rtl/lf_expect_lut.sv
// lf_expect_lut: golden {O1,O2} lookup for a given input vector
module lf_expect_lut #(
  parameter int N_IN = 3,
  parameter logic [2**N_IN-1:0] EXP_O1 = lf_bist_pkg::LF_EXP_O1,
  parameter logic [2**N_IN-1:0] EXP_O2 = lf_bist_pkg::LF_EXP_O2
) (
  input  logic [N_IN-1:0] vec_i,
  output logic [1:0]      exp_o
);
  assign exp_o = {EXP_O1[vec_i], EXP_O2[vec_i]};
endmodule

// File: rtl/logic_function_bist.sv
// logic_function_bist: sweeps all input vectors into logic_functions and checks O1/O2 against golden tables
module logic_function_bist
  import lf_bist_pkg::*;
#(
  parameter int N_IN = 3,
  parameter int SETTLE_CYCLES = 4,
  parameter logic [2**N_IN-1:0] EXP_O1 = LF_EXP_O1,
  parameter logic [2**N_IN-1:0] EXP_O2 = LF_EXP_O2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      obs,
  output logic [N_IN-1:0] vec,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN+1:0] err_count,
  output logic            fail_valid,
  output logic [N_IN-1:0] fail_vec,
  output logic [1:0]      fail_obs
);
  localparam int CW = SETTLE_CYCLES > 1 ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [N_IN-1:0] VEC_LAST = '1;
  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic [N_IN-1:0] vec_q, fvec_q;
  logic [N_IN+1:0] err_q, err_d;
  logic [N_IN+2:0] sum;
  logic [1:0]      fobs_q, exp_obs, mis;
  logic            fv_q;
  lf_expect_lut #(.N_IN(N_IN), .EXP_O1(EXP_O1), .EXP_O2(EXP_O2)) u_lut (
    .vec_i(vec_q),
    .exp_o(exp_obs)
  );
  assign mis   = obs ^ exp_obs;
  assign sum   = {1'b0, err_q} + (N_IN + 3)'(popcount2(mis));
  assign err_d = sum[N_IN+2] ? '1 : sum[N_IN+1:0];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      vec_q   <= '0;
      err_q   <= '0;
      fv_q    <= 1'b0;
      fvec_q  <= '0;
      fobs_q  <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: if (start) begin
          state_q <= SETTLE;
          cnt_q   <= '0;
          vec_q   <= '0;
          err_q   <= '0;
          fv_q    <= 1'b0;
          fvec_q  <= '0;
          fobs_q  <= '0;
        end
        SETTLE: if (cnt_q == CNT_LAST) state_q <= CHECK;
                else cnt_q <= cnt_q + CW'(1);
        CHECK: begin
          err_q <= err_d;
          if (|mis && !fv_q) begin
            fv_q   <= 1'b1;
            fvec_q <= vec_q;
            fobs_q <= obs;
          end
          if (vec_q == VEC_LAST) state_q <= DONE;
          else begin
            vec_q   <= vec_q + N_IN'(1);
            cnt_q   <= '0;
            state_q <= SETTLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign vec        = vec_q;
  assign busy       = state_q == SETTLE || state_q == CHECK;
  assign done       = state_q == DONE;
  assign pass       = done && err_q == '0;
  assign err_count  = err_q;
  assign fail_valid = fv_q;
  assign fail_vec   = fvec_q;
  assign fail_obs   = fobs_q;
endmodule
